pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register with a valid/ready handshake, flush, and an optional two-entry skid buffer. It is the next generation of the plain enabled register, intended for core pipeline boundaries such as IF/ID and ID/EX. Upstream stalls come from backpressure (out_ready) rather than a global write enable. Flush supports branch and jump squashing.

Parameters:
- N, 32, payload width in bits (N >= 1).
- RST_VAL, 0, N-bit value loaded into out_data on reset.
- SKID, 1. 1: two-entry skid buffer with registered in_ready. 0: single entry with combinational in_ready.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  discard all held entries at the next edge.
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage can accept data this cycle.
- in_data  input  N  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  N  head entry payload.
- count  output  2  number of held entries, 0..2 (0..1 when SKID=0).

Behaviour:
- Handshakes:
  - Input transfer ("acc") occurs when in_valid && in_ready at a posedge.
  - Output transfer ("take") occurs when out_valid && out_ready at a posedge.
  - Strict FIFO order; nothing is dropped or duplicated except by flush or rst.
- Reset (rst=1 at posedge):
  - out_valid=0, count=0, out_data=RST_VAL, skid entry invalid.
  - in_ready=0 in the cycle after any cycle with rst high if SKID=1; in_ready=1 once rst is low for one edge.
  - With SKID=0, in_ready = !out_valid || out_ready at all times (no rst gating).
  - rst has priority over flush and over any transfer.
- Flush (rst=0, flush=1 at posedge):
  - Both entries are invalidated; out_valid=0 and count=0 next cycle.
  - An acc in the same cycle is discarded.
  - A take in the same cycle still counts as consumed by downstream.
  - out_data keeps its value (not cleared).
- Latency: an accepted item appears on out_valid/out_data at the next cycle. No combinational path from in_data to out_data.
- Stability: while out_valid && !out_ready, out_data and out_valid must not change (except by flush or rst).
- out_data is don't-care but held when out_valid=0: it retains its last value and is updated only on load.
- SKID=1 state machine (main and skid registers):
  - EMPTY (count=0), in_ready=1:
    - acc -> ONE, main<=in_data.
  - ONE (count=1), in_ready=1:
    - acc && take -> ONE, main<=in_data.
    - acc && !take -> TWO, skid<=in_data.
    - take && !acc -> EMPTY.
    - neither -> ONE.
  - TWO (count=2), in_ready=0:
    - take -> ONE, main<=skid.
    - no take -> TWO.
  - in_ready is a register output, equal to !(next state==TWO) && !rst.
  - Sustained throughput is 1 item/cycle when out_ready=1.
- SKID=0:
  - Single main entry; in_ready = !out_valid || out_ready (combinational).
  - acc loads main and sets out_valid.
  - take without acc clears out_valid.
  - 1 item/cycle throughput.
- count equals the number of valid entries: out_valid + skid_valid.

Test Plan:
1. Reset: assert rst for 2 cycles with in_valid=1 and in_data=0xDEADBEEF, RST_VAL=0 -> out_valid=0, out_data=0, count=0 throughout. For SKID=1, in_ready=0 after the first rst edge and =1 one cycle after rst falls.
2. Streaming: out_ready=1, push 0x1,0x2,0x3,0x4 on consecutive cycles -> out_data shows 0x1..0x4 on the 4 following cycles, out_valid=1 each cycle, count=1, in_ready stays 1.
3. Backpressure (SKID=1):
   - Hold out_ready=0 and push 0xA,0xB,0xC -> 0xA and 0xB accepted, count=2, in_ready=0, 0xC held upstream, out_data=0xA stable.
   - Release out_ready -> outputs 0xA,0xB,0xC in order with no gaps once 0xC is accepted.
4. Flush: with count=2 (0xA,0xB), pulse flush while in_valid=1 with 0xC -> next cycle out_valid=0, count=0, in_ready=1. 0xC never appears. out_data still reads 0xA.
5. Reset mid-operation: count=2 and out_ready=1, assert rst for 1 cycle -> next cycle count=0, out_valid=0, out_data=RST_VAL. Previously held data never emerges.
6. SKID=0 mode, N=12:
   - in_ready follows out_ready combinationally while full.
   - push 0x123 with out_ready=0 -> held, in_ready=0.
   - Raise out_ready together with in_valid=1 and 0x456 -> same edge takes 0x123 and loads 0x456.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with valid/ready handshake, flush and optional skid entry
module pipe_stage_reg #(
  parameter int unsigned     N       = 32,
  parameter logic [N-1:0]    RST_VAL = '0,
  parameter bit              SKID    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t       state, state_n;
  logic [N-1:0] main_q, skid_q;
  logic         in_ready_q;
  logic         acc, take;
  logic         load_main, main_from_skid, load_skid;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign count     = state;

  // Without a skid entry the stage can only accept when its single slot is draining.
  assign in_ready  = SKID ? in_ready_q : (!out_valid || out_ready);

  assign acc  = in_valid && in_ready;
  assign take = out_valid && out_ready;

  always_comb begin
    state_n        = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state_n   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (acc && take) begin
            load_main = 1'b1;
          end else if (acc) begin
            state_n   = TWO;
            load_skid = 1'b1;
          end else if (take) begin
            state_n = EMPTY;
          end
        end
        TWO: begin
          if (take) begin
            state_n        = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_q     <= RST_VAL;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != TWO);
      if (load_main) main_q <= main_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed bench for pipe_stage_reg (skid and single-entry variants)
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_data, out_data;
  logic [1:0]  count;

  logic        flush0, in_valid0, out_ready0, in_ready0, out_valid0;
  logic [11:0] in_data0, out_data0;
  logic [1:0]  count0;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.N(32), .RST_VAL(32'h0), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  pipe_stage_reg #(.N(12), .RST_VAL(12'h0), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .count(count0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, out_valid); end
      tests++; if (out_data !== 32'h0) begin failed++; $display("FAIL reset_out_data[%0d]: got %h want 0", i, out_data); end
      tests++; if (count !== 2'd0) begin failed++; $display("FAIL reset_count[%0d]: got %0d want 0", i, count); end
      tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready[%0d]: got %b want 0", i, in_ready); end
    end
    rst = 1'b0;
    tick();
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_release_out_valid: got %b want 0", out_valid); end
    in_valid = 1'b0;
    tests++; if (out_valid0 !== 1'b0 || count0 !== 2'd0) begin failed++; $display("FAIL reset_skid0: got valid %b count %0d want 0 0", out_valid0, count0); end
  endtask

  task automatic test_streaming();
    logic [31:0] vals [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      tick();
      tests++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin failed++; $display("FAIL stream_out[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, vals[i]); end
      tests++; if (count !== 2'd1 || in_ready !== 1'b1) begin failed++; $display("FAIL stream_count_ready[%0d]: got %0d/%b want 1/1", i, count, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b0 || count !== 2'd0) begin failed++; $display("FAIL stream_drain: got %b/%0d want 0/0", out_valid, count); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    tests++; if (count !== 2'd1 || out_data !== 32'hA || in_ready !== 1'b1) begin failed++; $display("FAIL bp_first: got %0d/%h/%b want 1/a/1", count, out_data, in_ready); end
    in_data = 32'hB;
    tick();
    tests++; if (count !== 2'd2 || out_data !== 32'hA || in_ready !== 1'b0) begin failed++; $display("FAIL bp_full: got %0d/%h/%b want 2/a/0", count, out_data, in_ready); end
    in_data = 32'hC;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (count !== 2'd2 || out_data !== 32'hA || out_valid !== 1'b1 || in_ready !== 1'b0) begin failed++; $display("FAIL bp_hold[%0d]: got %0d/%h/%b/%b want 2/a/1/0", i, count, out_data, out_valid, in_ready); end
    end
    out_ready = 1'b1;
    tick();
    tests++; if (out_data !== 32'hB || count !== 2'd1 || in_ready !== 1'b1) begin failed++; $display("FAIL bp_release_b: got %h/%0d/%b want b/1/1", out_data, count, in_ready); end
    tick();
    tests++; if (out_data !== 32'hC || out_valid !== 1'b1 || count !== 2'd1) begin failed++; $display("FAIL bp_release_c: got %h/%b/%0d want c/1/1", out_data, out_valid, count); end
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b0 || count !== 2'd0) begin failed++; $display("FAIL bp_drain: got %b/%0d want 0/0", out_valid, count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    tests++; if (count !== 2'd2) begin failed++; $display("FAIL flush_setup: got %0d want 2", count); end
    in_data = 32'hC; flush = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1) begin failed++; $display("FAIL flush_clear: got %b/%0d/%b want 0/0/1", out_valid, count, in_ready); end
    tests++; if (out_data !== 32'hA) begin failed++; $display("FAIL flush_data_kept: got %h want a", out_data); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0 || out_data !== 32'hA) begin failed++; $display("FAIL flush_no_c: got %b/%h want 0/a", out_valid, out_data); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h55;
    tick();
    in_data = 32'h66;
    tick();
    tests++; if (count !== 2'd2) begin failed++; $display("FAIL rstmid_setup: got %0d want 2", count); end
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    tick();
    tests++; if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin failed++; $display("FAIL rstmid_clear: got %0d/%b/%h/%b want 0/0/0/0", count, out_valid, out_data, in_ready); end
    rst = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin failed++; $display("FAIL rstmid_after: got %b/%h/%b want 0/0/1", out_valid, out_data, in_ready); end
  endtask

  task automatic test_skid0();
    out_ready0 = 1'b0;
    tests++; if (in_ready0 !== 1'b1) begin failed++; $display("FAIL s0_idle_ready: got %b want 1", in_ready0); end
    in_valid0 = 1'b1; in_data0 = 12'h123;
    tick();
    tests++; if (out_valid0 !== 1'b1 || out_data0 !== 12'h123 || count0 !== 2'd1) begin failed++; $display("FAIL s0_load: got %b/%h/%0d want 1/123/1", out_valid0, out_data0, count0); end
    tests++; if (in_ready0 !== 1'b0) begin failed++; $display("FAIL s0_full_ready: got %b want 0", in_ready0); end
    in_valid0 = 1'b0;
    tick();
    tests++; if (out_data0 !== 12'h123 || out_valid0 !== 1'b1) begin failed++; $display("FAIL s0_hold: got %h/%b want 123/1", out_data0, out_valid0); end
    out_ready0 = 1'b1; #1;
    tests++; if (in_ready0 !== 1'b1) begin failed++; $display("FAIL s0_comb_ready_hi: got %b want 1", in_ready0); end
    out_ready0 = 1'b0; #1;
    tests++; if (in_ready0 !== 1'b0) begin failed++; $display("FAIL s0_comb_ready_lo: got %b want 0", in_ready0); end
    in_valid0 = 1'b1; in_data0 = 12'h456; out_ready0 = 1'b1;
    tick();
    tests++; if (out_data0 !== 12'h456 || out_valid0 !== 1'b1 || count0 !== 2'd1) begin failed++; $display("FAIL s0_swap: got %h/%b/%0d want 456/1/1", out_data0, out_valid0, count0); end
    in_valid0 = 1'b0;
    tick();
    tests++; if (out_valid0 !== 1'b0 || count0 !== 2'd0 || out_data0 !== 12'h456) begin failed++; $display("FAIL s0_drain: got %b/%0d/%h want 0/0/456", out_valid0, count0, out_data0); end
  endtask

  initial begin
    flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; in_data0 = 12'h0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_skid0();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
